// File: rtl/ialu_cmd_issuer_if.sv
// Handshake bundle between a requester, ialu_cmd_issuer and the IALU.
// Signal suffixes are kept from the issuer's point of view.
interface ialu_cmd_issuer_if #(
    parameter int unsigned SCR1_XLEN           = 32,
    parameter int unsigned SCR1_IALU_CMD_WIDTH = 5
);
    logic                           req_vd_i;
    logic                           req_rdy_o;
    logic                           req_rvm_i;
    logic [SCR1_IALU_CMD_WIDTH-1:0] req_cmd_i;
    logic [SCR1_XLEN-1:0]           req_main_op1_i;
    logic [SCR1_XLEN-1:0]           req_main_op2_i;
    logic [SCR1_XLEN-1:0]           req_addr_op1_i;
    logic [SCR1_XLEN-1:0]           req_addr_op2_i;

    logic                           rsp_vd_o;
    logic                           rsp_rdy_i;
    logic [SCR1_XLEN-1:0]           rsp_main_res_o;
    logic [SCR1_XLEN-1:0]           rsp_addr_res_o;
    logic                           rsp_cmp_res_o;
    logic                           rsp_tmo_o;

    logic                           ialu_rvm_cmd_vd_o;
    logic [SCR1_IALU_CMD_WIDTH-1:0] ialu_cmd_o;
    logic [SCR1_XLEN-1:0]           ialu_main_op1_o;
    logic [SCR1_XLEN-1:0]           ialu_main_op2_o;
    logic [SCR1_XLEN-1:0]           ialu_addr_op1_o;
    logic [SCR1_XLEN-1:0]           ialu_addr_op2_o;
    logic [SCR1_XLEN-1:0]           ialu_main_res_i;
    logic [SCR1_XLEN-1:0]           ialu_addr_res_i;
    logic                           ialu_cmp_res_i;
    logic                           ialu_rvm_res_rdy_i;

    modport slave (
        input  req_vd_i, req_rvm_i, req_cmd_i,
               req_main_op1_i, req_main_op2_i, req_addr_op1_i, req_addr_op2_i,
        output req_rdy_o,
        output rsp_vd_o, rsp_main_res_o, rsp_addr_res_o, rsp_cmp_res_o, rsp_tmo_o,
        input  rsp_rdy_i,
        output ialu_rvm_cmd_vd_o, ialu_cmd_o,
               ialu_main_op1_o, ialu_main_op2_o, ialu_addr_op1_o, ialu_addr_op2_o,
        input  ialu_main_res_i, ialu_addr_res_i, ialu_cmp_res_i, ialu_rvm_res_rdy_i
    );

    modport master (
        output req_vd_i, req_rvm_i, req_cmd_i,
               req_main_op1_i, req_main_op2_i, req_addr_op1_i, req_addr_op2_i,
        input  req_rdy_o,
        input  rsp_vd_o, rsp_main_res_o, rsp_addr_res_o, rsp_cmp_res_o, rsp_tmo_o,
        output rsp_rdy_i,
        input  ialu_rvm_cmd_vd_o, ialu_cmd_o,
               ialu_main_op1_o, ialu_main_op2_o, ialu_addr_op1_o, ialu_addr_op2_o,
        output ialu_main_res_i, ialu_addr_res_i, ialu_cmp_res_i, ialu_rvm_res_rdy_i
    );
endinterface

// File: rtl/ialu_cmd_issuer.sv
// Issues one IALU command at a time, waits for single-cycle or multi-cycle (RVM)
// results with a timeout, and holds the response until the consumer takes it.
module ialu_cmd_issuer #(
    parameter int unsigned SCR1_XLEN           = 32,
    parameter int unsigned SCR1_IALU_CMD_WIDTH = 5,
    parameter int unsigned TIMEOUT_CYC         = 64
) (
    input  logic              clk,
    input  logic              rst,
    ialu_cmd_issuer_if.slave  bus,
    output logic [15:0]       cnt_done_o
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t                         state_q;
    state_t                         state_d;

    logic                           req_rdy;
    logic                           accept;
    logic                           wait_last;
    logic                           cap_en;
    logic                           cap_zero;
    logic                           rsp_done;

    logic [15:0]                    wait_cnt_q;
    logic [15:0]                    cnt_q;
    logic                           rvm_cmd_vd_q;
    logic                           rsp_vd_q;

    logic [SCR1_IALU_CMD_WIDTH-1:0] cmd_q;
    logic [SCR1_XLEN-1:0]           main_op1_q;
    logic [SCR1_XLEN-1:0]           main_op2_q;
    logic [SCR1_XLEN-1:0]           addr_op1_q;
    logic [SCR1_XLEN-1:0]           addr_op2_q;

    logic [SCR1_XLEN-1:0]           main_res_q;
    logic [SCR1_XLEN-1:0]           addr_res_q;
    logic                           cmp_res_q;
    logic                           tmo_q;

    // Ready is gated by rst so it drops while reset is held, not just after.
    assign req_rdy   = (state_q == ST_IDLE) & ~rst;
    assign accept    = bus.req_vd_i & req_rdy;
    assign wait_last = (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = bus.req_rvm_i ? ST_WAIT : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            ST_WAIT: begin
                if (bus.ialu_rvm_res_rdy_i || wait_last) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_rdy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A result-ready seen in the last WAIT cycle beats the timeout.
    always_comb begin
        cap_en   = 1'b0;
        cap_zero = 1'b0;
        rsp_done = 1'b0;
        case (state_q)
            ST_ISSUE: cap_en = 1'b1;
            ST_WAIT: begin
                cap_en   = bus.ialu_rvm_res_rdy_i | wait_last;
                cap_zero = ~bus.ialu_rvm_res_rdy_i;
            end
            ST_RESP:  rsp_done = bus.rsp_rdy_i;
            default: begin
            end
        endcase
    end

    // Counts cycles spent in WAIT; zero on the first WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q != ST_WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvm_cmd_vd_q <= 1'b0;
            rsp_vd_q     <= 1'b0;
        end else begin
            rvm_cmd_vd_q <= (state_d == ST_WAIT);
            rsp_vd_q     <= (state_d == ST_RESP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q      <= '0;
            main_op1_q <= '0;
            main_op2_q <= '0;
            addr_op1_q <= '0;
            addr_op2_q <= '0;
        end else if (accept) begin
            cmd_q      <= bus.req_cmd_i;
            main_op1_q <= bus.req_main_op1_i;
            main_op2_q <= bus.req_main_op2_i;
            addr_op1_q <= bus.req_addr_op1_i;
            addr_op2_q <= bus.req_addr_op2_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_res_q <= '0;
            addr_res_q <= '0;
            cmp_res_q  <= 1'b0;
            tmo_q      <= 1'b0;
        end else if (cap_en) begin
            if (cap_zero) begin
                main_res_q <= '0;
                addr_res_q <= '0;
                cmp_res_q  <= 1'b0;
                tmo_q      <= 1'b1;
            end else begin
                main_res_q <= bus.ialu_main_res_i;
                addr_res_q <= bus.ialu_addr_res_i;
                cmp_res_q  <= bus.ialu_cmp_res_i;
                tmo_q      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (rsp_done) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.req_rdy_o         = req_rdy;
    assign bus.rsp_vd_o          = rsp_vd_q;
    assign bus.rsp_main_res_o    = main_res_q;
    assign bus.rsp_addr_res_o    = addr_res_q;
    assign bus.rsp_cmp_res_o     = cmp_res_q;
    assign bus.rsp_tmo_o         = tmo_q;
    assign bus.ialu_rvm_cmd_vd_o = rvm_cmd_vd_q;
    assign bus.ialu_cmd_o        = cmd_q;
    assign bus.ialu_main_op1_o   = main_op1_q;
    assign bus.ialu_main_op2_o   = main_op2_q;
    assign bus.ialu_addr_op1_o   = addr_op1_q;
    assign bus.ialu_addr_op2_o   = addr_op2_q;
    assign cnt_done_o            = cnt_q;

    a_rvm_vd_tracks_wait: assert property (
        @(posedge clk) disable iff (rst) rvm_cmd_vd_q == (state_q == ST_WAIT));
    a_rsp_vd_tracks_resp: assert property (
        @(posedge clk) disable iff (rst) rsp_vd_q == (state_q == ST_RESP));
    a_rsp_hold: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == ST_RESP && !bus.rsp_rdy_i) |=> (main_res_q == $past(main_res_q)));
endmodule
